// File: rtl/cache_pkg.sv
// Shared types for the cache request arbiter: op encoding, FSM states,
// and the default datapath widths.
package cache_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 10;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/cache_req_arbiter_rr_pick.sv
// Round-robin selector: first asserted valid strictly after 'last', with wrap,
// returned as a one-hot grant (all zero when nothing is valid).
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant
);

  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(last) + k) % N);
      if (!found && valid[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter funnelling N requesters onto one cache port with a single
// outstanding transaction, per-transaction timeout and one-cycle response pulses.
module cache_req_arbiter
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int N_REQ      = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_rw,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            resp_valid,
  output logic                        resp_err,
  output logic [DATA_WIDTH-1:0]       resp_rdata,
  output logic                        c_req_valid,
  input  logic                        c_req_ready,
  output logic                        c_rw,
  output logic [ADDR_WIDTH-1:0]       c_addr,
  output logic [DATA_WIDTH-1:0]       c_wdata,
  input  logic                        c_resp_valid,
  input  logic [DATA_WIDTH-1:0]       c_rdata,
  output logic                        busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  arb_state_e            state, state_nxt;
  logic [IW-1:0]         last_grant, grant, win_idx;
  logic [N_REQ-1:0]      win;
  op_e                   rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CW-1:0]         cnt;
  logic                  accept, tmo, done_ok, done_to;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .valid (req_valid),
    .last  (last_grant),
    .grant (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win[i]) win_idx = IW'(i);
  end

  assign req_ready   = (state == IDLE) ? win : '0;
  assign accept      = |(req_valid & req_ready);
  assign tmo         = (cnt == CW'(TIMEOUT - 1));
  assign c_req_valid = (state == ISSUE);
  assign c_rw        = rw_q;
  assign c_addr      = addr_q;
  assign c_wdata     = wdata_q;
  assign busy        = (state != IDLE);

  // A completion in the timeout cycle wins over the timeout.
  always_comb begin
    state_nxt = state;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        if (tmo) begin
          done_to   = 1'b1;
          state_nxt = IDLE;
        end else if (c_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (c_resp_valid) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (tmo) begin
          done_to   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IW'(N_REQ - 1);
      grant      <= '0;
      cnt        <= '0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_nxt;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      if (accept) begin
        grant <= win_idx;
        cnt   <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end
      if (done_ok) begin
        resp_valid <= N_REQ'(1) << grant;
        resp_rdata <= (rw_q == WRITE) ? '0 : c_rdata;
        last_grant <= grant;
      end else if (done_to) begin
        resp_valid <= N_REQ'(1) << grant;
        resp_err   <= 1'b1;
        last_grant <= grant;
      end
    end
  end

  // Request payload is only meaningful while a transaction is held.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= op_e'(req_rw[win_idx]);
      addr_q  <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_q <= req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: constant vector table, directed corner sequences
// and randomized transactions checked against a transaction-level model.
module tb_cache_req_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_rw, resp_valid;
  logic [19:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        c_req_valid, c_req_ready, c_rw, c_resp_valid, busy;
  logic [9:0]  c_addr;
  logic [31:0] c_wdata, c_rdata;

  int checks = 0;
  int errors = 0;

  cache_req_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .N_REQ(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_rw(c_rw),
    .c_addr(c_addr), .c_wdata(c_wdata),
    .c_resp_valid(c_resp_valid), .c_rdata(c_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  rw;
    logic [31:0] rd;
    int          idx;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Winner = first valid after 'last', wrapping around two requesters.
  function automatic int model_pick(input int last, input logic [1:0] v);
    int p;
    model_pick = -1;
    for (int k = 1; k <= 2; k++) begin
      p = (last + k) % 2;
      if (model_pick < 0 && v[p[0]]) model_pick = p;
    end
  endfunction

  task automatic run_txn(input logic [1:0] v, input logic [1:0] rw,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] rd, input int exp_idx,
                         input logic [31:0] exp_rd, input int d, input int r,
                         input string tag);
    logic [9:0]  ea;
    logic [31:0] ew;
    logic [1:0]  oh;
    ea = exp_idx[0] ? a1 : a0;
    ew = exp_idx[0] ? w1 : w0;
    oh = 2'b01 << exp_idx;
    @(posedge clk); #1;
    req_valid = v; req_rw = rw; req_addr = {a1, a0}; req_wdata = {w1, w0};
    c_req_ready = 1'b0; c_resp_valid = 1'($urandom % 2); c_rdata = $urandom;
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, oh);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_resp"}, resp_valid, 0);
    for (int k = 0; k <= d; k++) begin
      @(posedge clk); #1;
      req_valid = 2'b00; c_req_ready = (k == d); c_resp_valid = 1'($urandom % 2);
      @(negedge clk);
      chk({tag, "_c_valid"}, c_req_valid, 1);
      chk({tag, "_c_addr"}, c_addr, ea);
      chk({tag, "_c_wdata"}, c_wdata, ew);
      chk({tag, "_c_rw"}, c_rw, rw[exp_idx[0]]);
      chk({tag, "_issue_resp"}, resp_valid, 0);
    end
    for (int k = 0; k <= r; k++) begin
      @(posedge clk); #1;
      c_req_ready = 1'b0; c_resp_valid = (k == r); c_rdata = (k == r) ? rd : $urandom;
      @(negedge clk);
      chk({tag, "_wait_cvalid"}, c_req_valid, 0);
      chk({tag, "_wait_busy"}, busy, 1);
      chk({tag, "_wait_resp"}, resp_valid, 0);
    end
    @(posedge clk); #1;
    c_resp_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_resp_valid"}, resp_valid, oh);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_resp_busy"}, busy, 0);
  endtask

  vec_t tbl [8];

  initial begin
    int n, got, mlast, idx;
    int cyc [4];
    int ridx [4];
    logic [31:0] rdat [4];
    logic [1:0] v, rw;
    logic [9:0] a0, a1;
    logic [31:0] w0, w1, rd;

    tbl[0] = '{2'b11, 2'b00, 32'hAAAA0001, 0, 32'hAAAA0001};
    tbl[1] = '{2'b11, 2'b10, 32'hBBBB0002, 1, 32'h0};
    tbl[2] = '{2'b01, 2'b00, 32'hCCCC0003, 0, 32'hCCCC0003};
    tbl[3] = '{2'b01, 2'b01, 32'hDDDD0004, 0, 32'h0};
    tbl[4] = '{2'b10, 2'b00, 32'hEEEE0005, 1, 32'hEEEE0005};
    tbl[5] = '{2'b10, 2'b00, 32'h12345678, 1, 32'h12345678};
    tbl[6] = '{2'b11, 2'b00, 32'h0F0F0F0F, 0, 32'h0F0F0F0F};
    tbl[7] = '{2'b11, 2'b00, 32'h87654321, 1, 32'h87654321};

    reset = 1'b1; req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    c_req_ready = 1'b0; c_resp_valid = 1'b0; c_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_c_req_valid", c_req_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // Both requesters continuously valid, downstream answers in one cycle.
    @(posedge clk); #1;
    req_valid = 2'b11; req_rw = 2'b00; req_addr = {10'h3C5, 10'h005};
    c_req_ready = 1'b1; c_resp_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      c_rdata = 32'hA5A50000 | {22'd0, c_addr};
      @(negedge clk);
      if (resp_valid != 2'b00) begin
        cyc[n] = k; ridx[n] = (resp_valid == 2'b10) ? 1 : 0; rdat[n] = resp_rdata;
        chk("rr_onehot", $countones(resp_valid), 1);
        chk("rr_err", resp_err, 0);
        n++;
        if (n == 4) req_valid = 2'b00;
      end
    end
    chk("rr_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", ridx[i], i % 2);
      chk("rr_latency", cyc[i], 3 * (i + 1));
      chk("rr_rdata", rdat[i], (i % 2) ? 32'hA5A503C5 : 32'hA5A50005);
    end
    @(posedge clk); #1;
    c_req_ready = 1'b0; c_resp_valid = 1'b0;
    @(negedge clk);
    chk("rr_drained", busy, 0);

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].v, tbl[i].rw, 10'h005, 10'h3C5, 32'h11110000, 32'h22220000,
              tbl[i].rd, tbl[i].idx, tbl[i].exp_rd, i % 3, (i + 1) % 3, "tbl");

    // Write from requester 1 with a slow downstream accept.
    run_txn(2'b10, 2'b10, 10'h000, 10'h041, 32'h0, 32'hDEADBEEF,
            32'h13572468, 1, 32'h0, 3, 0, "wr");

    // Downstream never responds.
    @(posedge clk); #1;
    req_valid = 2'b01; req_rw = 2'b00; req_addr = {10'h3C5, 10'h005};
    c_req_ready = 1'b1; c_resp_valid = 1'b0;
    @(negedge clk);
    chk("to_ready", req_ready, 2'b01);
    got = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      if (resp_valid != 2'b00) begin
        got = k;
        chk("to_resp_valid", resp_valid, 2'b01);
        chk("to_resp_err", resp_err, 1);
        chk("to_resp_rdata", resp_rdata, 0);
        chk("to_busy", busy, 0);
        break;
      end
    end
    chk("to_latency", got, 65);
    c_req_ready = 1'b0;
    run_txn(2'b10, 2'b00, 10'h005, 10'h3C5, 32'h0, 32'h0,
            32'hCAFEF00D, 1, 32'hCAFEF00D, 0, 1, "post_to");

    // Completion arriving in the very cycle the timeout would fire.
    @(posedge clk); #1;
    req_valid = 2'b01; req_rw = 2'b00; c_req_ready = 1'b1;
    @(negedge clk);
    got = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      req_valid = 2'b00; c_resp_valid = (k == 64); c_rdata = 32'h5A5AC3C3;
      @(negedge clk);
      if (resp_valid != 2'b00) begin
        got = k;
        chk("tc_resp_valid", resp_valid, 2'b01);
        chk("tc_resp_err", resp_err, 0);
        chk("tc_resp_rdata", resp_rdata, 32'h5A5AC3C3);
        break;
      end
    end
    chk("tc_latency", got, 65);
    c_req_ready = 1'b0; c_resp_valid = 1'b0;

    // Stray completions while idle.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      c_resp_valid = (k < 2);
      @(negedge clk);
      chk("stray_resp", resp_valid, 0);
      chk("stray_busy", busy, 0);
    end

    mlast = 0;
    for (int t = 0; t < 30; t++) begin
      v = 2'($urandom_range(1, 3)); rw = 2'($urandom);
      a0 = 10'($urandom); a1 = 10'($urandom); w0 = $urandom; w1 = $urandom; rd = $urandom;
      idx = model_pick(mlast, v);
      run_txn(v, rw, a0, a1, w0, w1, rd, idx, rw[idx[0]] ? 32'h0 : rd,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rnd");
      mlast = idx;
    end

    // Leave last grant on requester 0, then reset in WAIT on requester 1's transaction.
    run_txn(2'b01, 2'b00, 10'h005, 10'h3C5, 32'h0, 32'h0,
            32'h0BADF00D, 0, 32'h0BADF00D, 0, 0, "pre_rst");
    @(posedge clk); #1;
    req_valid = 2'b10; req_rw = 2'b00; c_req_ready = 1'b1;
    @(negedge clk);
    chk("rw_ready", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    c_req_ready = 1'b0;
    @(negedge clk);
    chk("rw_in_wait", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("rw_c_req_valid", c_req_valid, 0);
    chk("rw_busy", busy, 0);
    chk("rw_resp_valid", resp_valid, 0);
    chk("rw_resp_err", resp_err, 0);
    chk("rw_resp_rdata", resp_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rw_first_pick", req_ready, 2'b01);
    chk("rw_no_resp", resp_valid, 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("rw_no_resp2", resp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_req_arbiter.md
CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, data word width (matches cache datapath) SHALL be provided.
REQ-002 Parameter ADDR_WIDTH, 10, block address width ({tag,index} of 1024-block main memory) SHALL be provided.
REQ-003 Parameter N_REQ, 2, number of requesters (2..8) SHALL be provided.
REQ-004 Parameter TIMEOUT, 64, max cycles from downstream issue to response SHALL be provided.
REQ-005 Ports SHALL be, one per line:
 clk  in  1  clock, rising edge
 reset  in  1  asynchronous, active-high
 req_valid  in  N_REQ  per-requester request valid
 req_ready  out  N_REQ  per-requester request accept
 req_rw  in  N_REQ  per-requester op, 0=READ 1=WRITE
 req_addr  in  N_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
 req_wdata  in  N_REQ*DATA_WIDTH  flattened write data, same packing
 resp_valid  out  N_REQ  one-cycle response pulse per requester
 resp_err  out  1  response was a timeout, qualified by any resp_valid
 resp_rdata  out  DATA_WIDTH  read data, qualified by resp_valid
 c_req_valid  out  1  downstream cache request valid
 c_req_ready  in  1  downstream accept
 c_rw  out  1  downstream op
 c_addr  out  ADDR_WIDTH  downstream address
 c_wdata  out  DATA_WIDTH  downstream write data
 c_resp_valid  in  1  downstream completion (reads and writes)
 c_rdata  in  DATA_WIDTH  downstream read data
 busy  out  1  high in any state except IDLE

Function
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT; only one transaction SHALL be outstanding.
REQ-007 In IDLE, winner SHALL be the first asserted req_valid scanning from (last_grant+1) mod N_REQ upward with wrap; req_ready SHALL be combinational, one-hot on the winner, asserted only in IDLE, zero when no req_valid.
REQ-008 On accept (req_valid&req_ready), rw/addr/wdata and grant index SHALL be latched; next state ISSUE.
REQ-009 In ISSUE, c_req_valid SHALL be 1 with c_rw/c_addr/c_wdata from latches, held stable until c_req_ready; on c_req_valid&c_req_ready go to WAIT.
REQ-010 In WAIT, on c_resp_valid: registered resp_valid[grant]=1 and resp_rdata=c_rdata (0 for writes) next cycle, resp_err=0, last_grant=grant, go IDLE.
REQ-011 Timeout counter SHALL clear on accept, increment each cycle in ISSUE/WAIT; when it reaches TIMEOUT-1 without completion: resp_valid[grant]=1, resp_err=1, resp_rdata=0 next cycle, c_req_valid dropped, last_grant=grant, go IDLE.
REQ-012 c_resp_valid and timeout in same cycle SHALL complete normally (resp_err=0).
REQ-013 c_resp_valid in IDLE or ISSUE SHALL be ignored (stray/late response).
REQ-014 Minimum latency: accept cycle T, c_req_valid at T+1, c_resp_valid at T+2 -> resp_valid at T+3; next accept possible at T+3.
REQ-015 resp_valid SHALL be at most one-hot and last exactly one cycle; req_valid deasserted before accept SHALL not be granted.

Reset
REQ-016 Reset SHALL force IDLE, last_grant=N_REQ-1 (requester 0 first priority), counter=0, resp_valid=0, resp_err=0, resp_rdata=0, c_req_valid=0, busy=0; in-flight transaction SHALL be dropped with no response.

Structure
REQ-017 Shared package cache_pkg SHALL hold the READ/WRITE op enum and ARB_STATE enum {IDLE,ISSUE,WAIT}; DATA_WIDTH/ADDR_WIDTH defaults SHALL come from it.
REQ-018 One sub-module rr_pick (round-robin priority selector: valid vector + pointer -> one-hot grant) SHALL be used; everything else flat.

Verification
REQ-019 Both valid continuously, reads to 0x005/0x3C5, downstream 1-cycle response -> grants alternate 0,1,0,1, each resp_valid on correct index with its data.
REQ-020 Requester 1 writes 0xDEADBEEF to 0x041, c_req_ready delayed 3 cycles -> c_wdata/c_addr stable throughout, resp_valid[1] with resp_err=0.
REQ-021 Downstream never responds, TIMEOUT=64 -> resp_valid[grant] with resp_err=1, resp_rdata=0, busy drops, next request served.
REQ-022 c_resp_valid in the timeout cycle -> resp_err=0 with c_rdata; stray c_resp_valid in IDLE -> no resp_valid.
REQ-023 Reset asserted in WAIT -> all outputs at reset values immediately; after release requester 0 wins a simultaneous request.
